// File: rtl/sprite_fetch_scheduler_if.sv
// Slot attribute mux port plus sprite-ROM row fetch port.
// Latency: slot_* returns combinationally in the same cycle as slot_idx.
// Backpressure: fetch_req holds with stable fields until fetch_ack.
interface sprite_fetch_scheduler_if;
  logic [3:0] slot_idx;
  logic       slot_en;
  logic [9:0] slot_x;
  logic [9:0] slot_y;
  logic [3:0] slot_gfx;
  logic       fetch_req;
  logic [3:0] fetch_gfx;
  logic [4:0] fetch_row;
  logic [9:0] fetch_x;
  logic       fetch_ack;

  // scheduler side
  modport master (
    output slot_idx, fetch_req, fetch_gfx, fetch_row, fetch_x,
    input  slot_en, slot_x, slot_y, slot_gfx, fetch_ack
  );

  // attribute mux / ROM side
  modport slave (
    input  slot_idx, fetch_req, fetch_gfx, fetch_row, fetch_x,
    output slot_en, slot_x, slot_y, slot_gfx, fetch_ack
  );
endinterface

// File: rtl/sprite_fetch_scheduler.sv
// Per-scanline sprite selection: scans all slots, queues hits, issues one ROM row fetch per hit.
// Latency: one slot per cycle after line_start; first fetch_req NUM_SLOTS+1 cycles after line_start.
// Backpressure: fetch_req held with stable head entry until fetch_ack; line_start aborts everything.
module sprite_fetch_scheduler #(
  parameter int NUM_SLOTS    = 16,
  parameter int MAX_PER_LINE = 4,
  parameter int SPR_H        = 32
) (
  input  logic                     clk_clk,
  input  logic                     reset_reset_n,
  input  logic                     line_start,
  input  logic [9:0]               next_line,
  sprite_fetch_scheduler_if.master bus,
  output logic                     busy,
  output logic                     line_done,
  output logic [2:0]               hit_count,
  output logic                     overflow
);

  localparam int         QW        = $clog2(MAX_PER_LINE);
  localparam logic [3:0] LAST_SLOT = 4'(NUM_SLOTS - 1);
  localparam logic [2:0] Q_DEPTH   = 3'(MAX_PER_LINE);

  typedef enum logic [1:0] {IDLE, SCAN, FETCH, DONE} state_t;

  state_t      state, state_nxt;
  logic [9:0]  line_q;
  logic [3:0]  scan_idx;
  logic [2:0]  rd_ptr;

  logic [3:0]  q_gfx [MAX_PER_LINE];
  logic [4:0]  q_row [MAX_PER_LINE];
  logic [9:0]  q_x   [MAX_PER_LINE];

  logic [10:0] row_diff;
  logic        slot_hit;
  logic        q_full;
  logic        push;
  logic        pop;
  logic        last_slot;
  logic        last_entry;

  // Hit test and queue handshake decode; 11-bit compare so a sprite below the line never wraps into a hit.
  always_comb begin
    row_diff   = {1'b0, line_q} - {1'b0, bus.slot_y};
    slot_hit   = bus.slot_en && (line_q >= bus.slot_y) && (row_diff < 11'(SPR_H));
    q_full     = (hit_count == Q_DEPTH);
    last_slot  = (scan_idx == LAST_SLOT);
    push       = (state == SCAN) && !line_start && slot_hit && !q_full;
    pop        = (state == FETCH) && !line_start && bus.fetch_ack;
    last_entry = (rd_ptr == (hit_count - 3'd1));
  end

  // State register.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) state <= IDLE;
    else                state <= state_nxt;
  end

  // Next-state and outputs; line_start from any state restarts the scan.
  always_comb begin
    state_nxt     = state;
    busy          = 1'b0;
    line_done     = 1'b0;
    bus.slot_idx  = scan_idx;
    bus.fetch_req = 1'b0;
    bus.fetch_gfx = '0;
    bus.fetch_row = '0;
    bus.fetch_x   = '0;
    case (state)
      IDLE: ;
      SCAN: begin
        busy = 1'b1;
        if (last_slot) state_nxt = ((hit_count != 3'd0) || push) ? FETCH : DONE;
      end
      FETCH: begin
        busy          = 1'b1;
        bus.fetch_req = 1'b1;
        bus.fetch_gfx = q_gfx[rd_ptr[QW-1:0]];
        bus.fetch_row = q_row[rd_ptr[QW-1:0]];
        bus.fetch_x   = q_x[rd_ptr[QW-1:0]];
        if (pop && last_entry) state_nxt = DONE;
      end
      DONE: begin
        line_done = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (line_start) state_nxt = SCAN;
  end

  // Line latch, scan counter, hit accounting and fetch head pointer.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      line_q    <= '0;
      scan_idx  <= '0;
      hit_count <= '0;
      overflow  <= 1'b0;
      rd_ptr    <= '0;
    end else if (line_start) begin
      line_q    <= next_line;
      scan_idx  <= '0;
      hit_count <= '0;
      overflow  <= 1'b0;
      rd_ptr    <= '0;
    end else begin
      if (state == SCAN) begin
        scan_idx <= last_slot ? 4'd0 : scan_idx + 4'd1;
        if (slot_hit) begin
          if (q_full) overflow  <= 1'b1;
          else        hit_count <= hit_count + 3'd1;
        end
      end
      if (pop) rd_ptr <= rd_ptr + 3'd1;
    end
  end

  // Hit queue storage; validity is tracked by hit_count/rd_ptr so the contents need no reset.
  always_ff @(posedge clk_clk) begin
    if (push) begin
      q_gfx[hit_count[QW-1:0]] <= bus.slot_gfx;
      q_row[hit_count[QW-1:0]] <= row_diff[4:0];
      q_x[hit_count[QW-1:0]]   <= bus.slot_x;
    end
  end

endmodule

// File: tb/tb_sprite_fetch_scheduler.sv
// Scoreboard bench for sprite_fetch_scheduler: slot table drives the attribute mux, expected fetches queued per line.
// Latency: checks first event 16 samples after the line_start edge and line_done right after the last ack.
// Backpressure: ack delay is programmable; fetch fields are compared against the scoreboard head every req cycle.
module tb_sprite_fetch_scheduler;

  logic       clk_clk;
  logic       reset_reset_n;
  logic       line_start;
  logic [9:0] next_line;
  logic       busy;
  logic       line_done;
  logic [2:0] hit_count;
  logic       overflow;

  sprite_fetch_scheduler_if bus();

  sprite_fetch_scheduler dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .line_start    (line_start),
    .next_line     (next_line),
    .bus           (bus),
    .busy          (busy),
    .line_done     (line_done),
    .hit_count     (hit_count),
    .overflow      (overflow)
  );

  logic       sl_en  [16];
  logic [9:0] sl_x   [16];
  logic [9:0] sl_y   [16];
  logic [3:0] sl_gfx [16];

  assign bus.slot_en  = sl_en[bus.slot_idx];
  assign bus.slot_x   = sl_x[bus.slot_idx];
  assign bus.slot_y   = sl_y[bus.slot_idx];
  assign bus.slot_gfx = sl_gfx[bus.slot_idx];

  initial clk_clk = 1'b0;
  always #5 clk_clk = ~clk_clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int start_cyc = 0;
  int last_hs_n = 0;
  int req_cycles = 0;
  int done_cnt = 0;
  int wait_cnt = 0;
  int ack_delay = 0;
  bit ack_en = 1'b1;
  int exp_hits = 0;
  bit exp_ovf = 1'b0;
  logic [18:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // One clock: drive ack, check presented fetch against scoreboard head, advance, retire handshakes.
  task automatic tick();
    logic hs;
    if (bus.fetch_req && ack_en) begin
      bus.fetch_ack = (wait_cnt >= ack_delay);
      if (!bus.fetch_ack) wait_cnt++;
    end else begin
      bus.fetch_ack = 1'b0;
    end
    if (bus.fetch_req) begin
      req_cycles++;
      if (exp_q.size() > 0)
        check("fetch_dat", {13'd0, bus.fetch_gfx, bus.fetch_row, bus.fetch_x}, {13'd0, exp_q[0]});
      else
        check("fetch_req_unexpected", {31'd0, bus.fetch_req}, 32'd0);
    end
    hs = bus.fetch_req && bus.fetch_ack && !line_start;
    @(posedge clk_clk);
    #1;
    cyc++;
    if (hs) begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      wait_cnt  = 0;
      last_hs_n = cyc;
    end
    if (line_done) done_cnt++;
  endtask

  task automatic clear_slots();
    for (int i = 0; i < 16; i++) begin
      sl_en[i] = 1'b0; sl_x[i] = '0; sl_y[i] = '0; sl_gfx[i] = '0;
    end
  endtask

  task automatic set_slot(input int i, input int x, input int y, input int g);
    sl_en[i] = 1'b1; sl_x[i] = 10'(x); sl_y[i] = 10'(y); sl_gfx[i] = 4'(g);
  endtask

  // Reference selection for a line: ascending slot order, first four hits kept.
  task automatic model_line(input int line);
    int cnt;
    cnt = 0;
    exp_ovf = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 16; i++) begin
      if (sl_en[i] && line >= int'(sl_y[i]) && (line - int'(sl_y[i])) < 32) begin
        if (cnt < 4) begin
          exp_q.push_back({sl_gfx[i], 5'(line - int'(sl_y[i])), sl_x[i]});
          cnt++;
        end else begin
          exp_ovf = 1'b1;
        end
      end
    end
    exp_hits = cnt;
  endtask

  task automatic start_line(input int line);
    line_start = 1'b1;
    next_line  = 10'(line);
    tick();
    line_start = 1'b0;
    start_cyc  = cyc;
    model_line(line);
    req_cycles = 0;
    done_cnt   = 0;
    wait_cnt   = 0;
    check("scan_busy", {31'd0, busy}, 32'd1);
    check("scan_slot0", {28'd0, bus.slot_idx}, 32'd0);
    check("scan_no_req", {31'd0, bus.fetch_req}, 32'd0);
  endtask

  task automatic finish_line();
    int first;
    int guard;
    first = -1;
    guard = 0;
    while (!line_done && guard < 400) begin
      tick();
      guard++;
      if ((cyc - start_cyc) == 15) begin
        check("scan_slot15", {28'd0, bus.slot_idx}, 32'd15);
        check("scan_busy15", {31'd0, busy}, 32'd1);
      end
      if (first < 0 && (bus.fetch_req || line_done)) first = cyc - start_cyc;
    end
    check("line_done_seen", {31'd0, line_done}, 32'd1);
    check("first_event_cycle", 32'(first), 32'd16);
    check("done_busy_low", {31'd0, busy}, 32'd0);
    check("hit_count", {29'd0, hit_count}, 32'(exp_hits));
    check("overflow", {31'd0, overflow}, {31'd0, exp_ovf});
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    check("req_cycles", 32'(req_cycles), 32'(exp_hits * (ack_delay + 1)));
    if (exp_hits > 0) check("done_after_last_ack", 32'(cyc), 32'(last_hs_n));
    tick();
    check("done_pulse_1cyc", {31'd0, line_done}, 32'd0);
    check("done_count", 32'(done_cnt), 32'd1);
    check("hold_hit_count", {29'd0, hit_count}, 32'(exp_hits));
    check("hold_overflow", {31'd0, overflow}, {31'd0, exp_ovf});
  endtask

  task automatic wait_req();
    for (int i = 0; i < 40 && !bus.fetch_req; i++) tick();
    check("req_seen", {31'd0, bus.fetch_req}, 32'd1);
  endtask

  task automatic two_hit_slots();
    clear_slots();
    set_slot(2, 120, 100, 3);
    set_slot(5, 250, 69, 9);
    set_slot(7, 333, 68, 5);
    set_slot(9, 444, 101, 6);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_reset_n = 1'b0;
    line_start    = 1'b0;
    next_line     = '0;
    bus.fetch_ack = 1'b0;
    clear_slots();
    #12;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_req", {31'd0, bus.fetch_req}, 32'd0);
    check("rst_slot_idx", {28'd0, bus.slot_idx}, 32'd0);
    check("rst_hit_count", {29'd0, hit_count}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_line_done", {31'd0, line_done}, 32'd0);
    check("rst_fetch_x", {22'd0, bus.fetch_x}, 32'd0);
    tick();
    reset_reset_n = 1'b1;
    tick();
    tick();

    // no hits at all
    ack_delay = 0;
    start_line(100);
    finish_line();

    // two hits including row 0 / row 31 edges and both near misses, back-to-back acks
    two_hit_slots();
    start_line(100);
    finish_line();

    // overflow: six slots on the line, only the four lowest kept
    clear_slots();
    for (int i = 0; i < 6; i++) set_slot(i, 10 + 40 * i, 50, i + 1);
    start_line(60);
    finish_line();

    // ack stalls of three cycles per fetch
    two_hit_slots();
    ack_delay = 3;
    start_line(100);
    finish_line();
    ack_delay = 0;

    // restart mid-FETCH with an unacked request pending
    clear_slots();
    for (int i = 0; i < 6; i++) set_slot(i, 10 + 40 * i, 50, i + 1);
    set_slot(12, 300, 190, 12);
    ack_en = 1'b0;
    start_line(60);
    wait_req();
    tick();
    tick();
    check("restart_no_old_done", 32'(done_cnt), 32'd0);
    start_line(200);
    check("restart_req_dropped", {31'd0, bus.fetch_req}, 32'd0);
    check("restart_no_done", {31'd0, line_done}, 32'd0);
    ack_en = 1'b1;
    finish_line();

    // asynchronous reset between edges while a fetch is pending
    two_hit_slots();
    ack_en = 1'b0;
    start_line(100);
    wait_req();
    #3;
    reset_reset_n = 1'b0;
    #1;
    check("arst_req", {31'd0, bus.fetch_req}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_hit_count", {29'd0, hit_count}, 32'd0);
    check("arst_fetch_x", {22'd0, bus.fetch_x}, 32'd0);
    check("arst_slot_idx", {28'd0, bus.slot_idx}, 32'd0);
    exp_q.delete();
    done_cnt = 0;
    tick();
    reset_reset_n = 1'b1;
    tick();
    check("arst_no_done", 32'(done_cnt), 32'd0);
    ack_en = 1'b1;
    start_line(100);
    finish_line();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sprite_fetch_scheduler.md
Name: sprite_fetch_scheduler

Overview:
Per-scanline sprite scheduler between the game-state export registers (samus/monster/bullet/explosion/kraid x/y/en) and the shared sprite-ROM fetch port. At each line_start it scans all sprite slots, selects up to MAX_PER_LINE sprites intersecting the next line, and issues one ROM row fetch per selected sprite over a req/ack handshake. Downstream line-buffer logic consumes fetch_* fields.

Parameters:
NUM_SLOTS, 16, number of sprite slots scanned (slot_idx width = clog2(NUM_SLOTS))
MAX_PER_LINE, 4, hit queue depth / max sprites fetched per line
SPR_H, 32, sprite height in rows (power of 2, ≤32)

Ports:
clk_clk  in  1  system clock
reset_reset_n  in  1  reset; asynchronous, active-low
line_start  in  1  one-cycle pulse at hblank start
next_line  in  10  line to prepare; sampled when line_start=1
slot_idx  out  4  slot select to external attribute mux (combinational return, same cycle)
slot_en  in  1  selected slot enable
slot_x  in  10  selected slot x
slot_y  in  10  selected slot top y
slot_gfx  in  4  selected slot graphic id
fetch_req  out  1  fetch request valid
fetch_gfx  out  4  graphic id of fetch
fetch_row  out  5  row within sprite (next_line - slot_y)
fetch_x  out  10  screen x of fetch
fetch_ack  in  1  ROM port accepted current fetch
busy  out  1  high in SCAN or FETCH
line_done  out  1  one-cycle pulse when line finished
hit_count  out  3  hits queued for current line (saturates at MAX_PER_LINE)
overflow  out  1  ≥1 hit dropped this line

Behaviour:
- Reset (async assert): state IDLE; slot_idx=0, fetch_req=0, fetch_gfx/row/x=0, busy=0, line_done=0, hit_count=0, overflow=0, queue empty, latched line=0.
- States: IDLE, SCAN, FETCH, DONE.
- IDLE: on line_start latch next_line, clear hit_count/overflow/queue, go SCAN with slot_idx=0.
- SCAN: one slot per cycle, slot_idx 0..NUM_SLOTS-1 ascending. Hit = slot_en && line ≥ slot_y && (line − slot_y) < SPR_H; compare in 11-bit unsigned (no wrap: slot_y > line is a miss). Hit with queue not full: push {slot_gfx, (line−slot_y)[4:0], slot_x}, hit_count+1. Hit with queue full: drop, overflow=1 (lower index has priority). After slot NUM_SLOTS-1: FETCH if hit_count>0 else DONE.
- Timing: line_start at edge k → slot i evaluated in cycle k+1+i; first fetch_req (or DONE) in cycle k+1+NUM_SLOTS.
- FETCH: fetch_req=1 with head entry on fetch_*; fields stable until ack. fetch_ack sampled high while fetch_req=1 pops head; next entry presented next cycle (req stays high, back-to-back allowed). Ack on last entry → DONE. fetch_ack while fetch_req=0 ignored.
- DONE: line_done=1 for exactly one cycle, busy=0, then IDLE. hit_count/overflow hold until next line_start.
- line_start in SCAN/FETCH/DONE: abort current line, drop queue and any pending (unacked) request, fetch_req=0 that cycle's next edge, restart SCAN with new line; no line_done for the aborted line. line_start coincident with fetch_ack: ack is discarded, restart wins.
- Reset mid-operation: immediate return to reset values; no line_done.

Test Plan:
- No hits: all slot_en=0, line_start next_line=100 → busy 16 cycles, no fetch_req, line_done at cycle k+17, hit_count=0.
- Two hits + edges: line=100; slot2 y=100 (row 0), slot5 y=69 (row 31), slot7 y=68 (miss), slot9 y=101 (miss) → fetches slot2 then slot5, rows 0 and 31, hit_count=2, overflow=0.
- Overflow: slots 0..5 enabled, y=50, line=60 → fetches slots 0..3 only, all row 10, hit_count=4, overflow=1.
- Ack stall: 2 hits, fetch_ack delayed 3 cycles each → fetch_* stable while waiting; line_done 1 cycle after 2nd ack; continuous ack → back-to-back fetches.
- Restart: line_start during FETCH with line=200, 1 pending unacked → req drops, rescan for 200, no line_done for old line.
- Async reset asserted mid-FETCH between edges → outputs zero immediately; post-release line_start works normally.
